credit_sender: RTL

Transmit end of the credit-based FIFO link. It accepts words from an upstream valid/ready source and launches each one onto the link, but only when it holds a credit. It starts with DEPTH credits and regains them from receiver-side credit returns. The link itself has no backpressure, so the receiving FIFO can never overflow while this block follows the credit rules.

---
 rtl/fifo_credit_pkg.sv | 14 +
 rtl/credit_counter.sv | 44 ++++
 rtl/credit_sender.sv | 77 +++++++
 3 files changed

// File: rtl/fifo_credit_pkg.sv
// Shared types and defaults for the credit-based FIFO link (sender and receiver sides).
package fifo_credit_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } state_t;

  typedef logic [DEF_ADDR_W:0] credit_t;

endpackage

// File: rtl/credit_counter.sv
// Credit counter: loads DEPTH on reset, applies send/return each cycle, flags overflow.
module credit_counter
  import fifo_credit_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RTN_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              send,
  input  logic              rtn_valid,
  input  logic [RTN_W-1:0]  rtn_cnt,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   outstanding,
  output logic              ovf
);

  // Two extra bits so count + a full return can never wrap before the compare.
  localparam int SUM_W = ADDR_W + 2;

  logic [SUM_W-1:0] rtn_ext;
  logic [SUM_W-1:0] next_sum;

  always_comb begin
    rtn_ext  = rtn_valid ? SUM_W'(rtn_cnt) : '0;
    next_sum = SUM_W'(count) - SUM_W'(send) + rtn_ext;
  end

  assign ovf = en && (next_sum > SUM_W'(DEPTH));

  // On overflow the count is frozen; outstanding moves in lockstep so the sum stays DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= (ADDR_W+1)'(DEPTH);
      outstanding <= '0;
    end else if (en && !ovf) begin
      count       <= next_sum[ADDR_W:0];
      outstanding <= (ADDR_W+1)'(DEPTH) - next_sum[ADDR_W:0];
    end
  end

endmodule

// File: rtl/credit_sender.sv
// Transmit end of the credit-based link: launches upstream words only while holding credits.
// Handshake: a word transfers on a rising edge where wr_valid && wr_ready; wr_ready depends only on registered state.
module credit_sender
  import fifo_credit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RTN_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  crd_rtn_valid,
  input  logic [RTN_W-1:0]      crd_rtn_cnt,
  output logic [ADDR_W:0]       credit_avail,
  output logic [ADDR_W:0]       outstanding,
  output logic                  crd_err,
  output state_t                dbg_state
);

  state_t state;
  state_t state_nxt;
  logic   send;
  logic   ovf;

  assign send = wr_valid && wr_ready;

  credit_counter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .RTN_W  (RTN_W)
  ) u_credit_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state == RUN),
    .send        (send),
    .rtn_valid   (crd_rtn_valid),
    .rtn_cnt     (crd_rtn_cnt),
    .count       (credit_avail),
    .outstanding (outstanding),
    .ovf         (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // ERR is terminal: only rst_n brings the link back.
  always_comb begin
    state_nxt = state;
    if (state == RUN && ovf) state_nxt = ERR;
  end

  always_comb begin
    wr_ready  = (state == RUN) && (credit_avail != '0);
    crd_err   = (state == ERR);
    dbg_state = state;
  end

  // A send in the overflow cycle still launches; tx_data holds between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_valid <= send;
      if (send) tx_data <= wr_data;
    end
  end

endmodule
